pwm_fade_ctrl: RTL and testbench

Command-driven duty-cycle sequencer that sits between `clkDivHz` (rate strobe) and `pwm` (output stage). It owns the `dutyCycle` register and accepts one command at a time over a valid/ready handshake. Commands can jump to a level, ramp to a target at a programmable step per tick, or breathe continuously between two bounds. This replaces the ad-hoc fade counters in top-level designs.

---
 rtl/pwm_fade_ctrl.sv | 141 ++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// Command-driven duty-cycle sequencer: jump, ramp or breathe the PWM duty level,
// one command at a time over a valid/ready handshake, stepping on each tick strobe.
module pwm_fade_ctrl #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_mode_i,
    input  logic [Width-1:0] cmd_level_a_i,
    input  logic [Width-1:0] cmd_level_b_i,
    input  logic [Width-1:0] cmd_step_i,
    output logic [Width-1:0] duty_cycle_o,
    output logic             busy_o,
    output logic             done_pulse_o
);

    typedef enum logic [1:0] {StIdle, StRamp, StBrthUp, StBrthDn} state_e;

    localparam logic [1:0] ModeSet     = 2'd0;
    localparam logic [1:0] ModeRamp    = 2'd1;
    localparam logic [1:0] ModeBreathe = 2'd2;

    state_e           state_q;
    logic [Width-1:0] duty_q;
    logic [Width-1:0] lvl_a_q;
    logic [Width-1:0] lvl_b_q;
    logic [Width-1:0] step_q;
    logic             dir_up_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic [Width-1:0] eff_step;
    logic [Width-1:0] up_tgt;
    logic [Width:0]   up_sum;
    logic [Width:0]   dn_diff;
    logic [Width-1:0] up_next;
    logic [Width-1:0] dn_next;
    logic [Width-1:0] ramp_next;

    // Extra top bit catches carry/borrow so the step clamps at the bound instead of wrapping.
    always_comb begin
        cmd_ready_o = !rst_i && (state_q != StRamp);
        accept      = cmd_valid_i && cmd_ready_o;
        eff_step    = (cmd_step_i == '0) ? Width'(1) : cmd_step_i;
        up_tgt      = (state_q == StRamp) ? lvl_a_q : lvl_b_q;
        up_sum      = {1'b0, duty_q} + {1'b0, step_q};
        dn_diff     = {1'b0, duty_q} - {1'b0, step_q};
        up_next     = (up_sum >= {1'b0, up_tgt}) ? up_tgt : up_sum[Width-1:0];
        dn_next     = (dn_diff[Width] || (dn_diff[Width-1:0] <= lvl_a_q)) ? lvl_a_q
                                                                         : dn_diff[Width-1:0];
        ramp_next   = dir_up_q ? up_next : dn_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            duty_q   <= '0;
            lvl_a_q  <= '0;
            lvl_b_q  <= '0;
            step_q   <= Width'(1);
            dir_up_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                // A command always wins over a coincident tick.
                lvl_a_q  <= cmd_level_a_i;
                lvl_b_q  <= cmd_level_b_i;
                step_q   <= eff_step;
                dir_up_q <= cmd_level_a_i > duty_q;
                case (cmd_mode_i)
                    ModeSet: begin
                        duty_q  <= cmd_level_a_i;
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    ModeRamp: begin
                        if (cmd_level_a_i == duty_q) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRamp;
                            busy_q  <= 1'b1;
                        end
                    end
                    ModeBreathe: begin
                        duty_q <= cmd_level_a_i;
                        if (cmd_level_a_i >= cmd_level_b_i) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StBrthUp;
                            busy_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end else if (tick_i) begin
                case (state_q)
                    StRamp: begin
                        duty_q <= ramp_next;
                        if (ramp_next == lvl_a_q) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    StBrthUp: begin
                        duty_q <= up_next;
                        if (up_next == lvl_b_q) begin
                            state_q <= StBrthDn;
                        end
                    end
                    StBrthDn: begin
                        duty_q <= dn_next;
                        if (dn_next == lvl_a_q) begin
                            state_q <= StBrthUp;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign duty_cycle_o = duty_q;
    assign busy_o       = busy_q;
    assign done_pulse_o = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: an integer reference model queues per-cycle expectations
// and completion levels; an independent monitor pops and compares on each falling edge.
module tb_pwm_fade_ctrl;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [7:0] cmd_step;
    logic [7:0] duty;
    logic       busy;
    logic       done;

    pwm_fade_ctrl #(.Width(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tick_i       (tick),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_mode_i   (cmd_mode),
        .cmd_level_a_i(cmd_a),
        .cmd_level_b_i(cmd_b),
        .cmd_step_i   (cmd_step),
        .duty_cycle_o (duty),
        .busy_o       (busy),
        .done_pulse_o (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int duty;
        bit busy;
        bit done;
        bit ready;
    } exp_t;

    exp_t exp_q[$];
    int   done_lvl_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: 0 idle, 1 ramping, 2 breathing up, 3 breathing down.
    int m_duty = 0;
    int m_st   = 0;
    int m_tgt  = 0;
    int m_lo   = 0;
    int m_hi   = 0;
    int m_step = 1;
    bit m_up   = 0;
    bit m_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_finish();
        m_st   = 0;
        m_done = 1;
        done_lvl_q.push_back(m_duty);
    endtask

    task automatic model_step(input bit r, input bit t, input bit acc, input int m, input int a,
                              input int b, input int s);
        int eff;
        eff    = (s == 0) ? 1 : s;
        m_done = 0;
        if (r) begin
            m_duty = 0;
            m_st   = 0;
        end else if (acc) begin
            case (m)
                0: begin
                    m_duty = a;
                    model_finish();
                end
                1: begin
                    if (a == m_duty) model_finish();
                    else begin
                        m_st   = 1;
                        m_tgt  = a;
                        m_step = eff;
                        m_up   = a > m_duty;
                    end
                end
                2: begin
                    m_duty = a;
                    if (a >= b) model_finish();
                    else begin
                        m_lo   = a;
                        m_hi   = b;
                        m_step = eff;
                        m_st   = 2;
                    end
                end
                default: m_st = 0;
            endcase
        end else if (t) begin
            case (m_st)
                1: begin
                    if (m_up) m_duty = (m_duty + m_step > m_tgt) ? m_tgt : m_duty + m_step;
                    else      m_duty = (m_duty - m_step < m_tgt) ? m_tgt : m_duty - m_step;
                    if (m_duty == m_tgt) model_finish();
                end
                2: begin
                    m_duty = (m_duty + m_step > m_hi) ? m_hi : m_duty + m_step;
                    if (m_duty == m_hi) m_st = 3;
                end
                3: begin
                    m_duty = (m_duty - m_step < m_lo) ? m_lo : m_duty - m_step;
                    if (m_duty == m_lo) m_st = 2;
                end
                default: ;
            endcase
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, queue what the monitor should
    // see at the next falling edge, then advance the model across the coming edge.
    task automatic drive(input bit r, input bit t, input bit v, input int m, input int a,
                         input int b, input int s);
        exp_t e;
        bit   rdy;
        #1;
        rst       = r;
        tick      = t;
        cmd_valid = v;
        cmd_mode  = m[1:0];
        cmd_a     = a[7:0];
        cmd_b     = b[7:0];
        cmd_step  = s[7:0];
        rdy       = !r && (m_st != 1);
        e.duty    = m_duty;
        e.busy    = (m_st != 0);
        e.done    = m_done;
        e.ready   = rdy;
        exp_q.push_back(e);
        model_step(r, t, v && rdy, m, a, b, s);
        @(posedge clk);
    endtask

    task automatic run(input int n, input int tick_per, input bit v, input int m, input int a,
                       input int b, input int s);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, (tick_per > 0) && (i % tick_per == tick_per - 1), v, m, a, b, s);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("duty", {24'd0, duty}, e.duty);
                chk("busy", {31'd0, busy}, {31'd0, e.busy});
                chk("done_pulse", {31'd0, done}, {31'd0, e.done});
                chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, e.ready});
            end
            if (done === 1'b1) begin
                if (done_lvl_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
                else chk("done_level", {24'd0, duty}, done_lvl_q.pop_front());
            end
        end
    end

    initial begin
        rst       = 1'b1;
        tick      = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_a     = 8'd0;
        cmd_b     = 8'd0;
        cmd_step  = 8'd0;
        repeat (2) @(posedge clk);

        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        run(3, 0, 0, 0, 0, 0, 0);

        drive(0, 0, 1, 0, 128, 0, 0);           // SET 128
        run(3, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);             // SET 0
        run(2, 0, 0, 0, 0, 0, 0);

        drive(0, 0, 1, 1, 10, 0, 4);            // RAMP 0 -> 10 step 4
        run(10, 5, 1, 0, 77, 0, 0);             // SET held during ramp, must be refused
        run(10, 5, 0, 0, 0, 0, 0);

        drive(0, 0, 1, 1, 0, 0, 3);             // RAMP 10 -> 0 step 3
        run(6, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 250, 0, 0);
        drive(0, 0, 1, 1, 255, 0, 10);          // RAMP 250 -> 255 step 10
        run(3, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 252, 0, 0);           // step 0 acts as 1
        run(5, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 252, 0, 9);           // already at target
        run(2, 0, 0, 0, 0, 0, 0);

        drive(0, 0, 1, 2, 1, 254, 1);           // BREATHE 1..254
        run(906, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 3, 0, 0, 0);             // STOP mid-descent
        run(5, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 3, 0, 0, 0);             // STOP in idle
        run(2, 0, 0, 0, 0, 0, 0);

        drive(0, 0, 1, 2, 20, 100, 7);
        run(6, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 50, 0, 0);            // tick and SET together
        run(3, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 2, 90, 30, 2);           // A >= B behaves as SET
        run(2, 0, 0, 0, 0, 0, 0);

        drive(0, 0, 1, 1, 200, 0, 5);           // RAMP aborted by reset
        run(6, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 9, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        run(3, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3),
                  $urandom_range(0, 255), $urandom_range(0, 255),
                  ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40));
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        run(5, 1, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        chk("expect_queue_drained", exp_q.size(), 0);
        chk("done_queue_drained", done_lvl_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
